act_writeback: RTL and testbench

- Downstream stage of the systolic result path.
- Drains the 8 result rows (8 lanes x 20-bit signed partial sums) from the result SRAM and applies optional ReLU, then a rounding arithmetic right shift and saturation to signed 8-bit.
- Writes the 8 requantised 64-bit words back into the unified buffer, so they can feed the next layer.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/act_writeback_if.sv | 27 ++
 rtl/act_quant_lane.sv | 49 ++++
 rtl/act_writeback.sv | 99 +++++++++
 tb/tb_act_writeback.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared widths, FSM encoding and saturation limits for the result write-back path.
package tpu_pkg;

    localparam int unsigned PARTIAL_SUM_BW = 20;
    localparam int unsigned DATA_BW        = 8;
    localparam int unsigned MATRIX_SIZE    = 8;
    localparam int unsigned NUM_ROWS       = 8;
    localparam int unsigned ADDRESSSIZE    = 10;
    localparam int unsigned SHIFT_BW       = 5;
    localparam int unsigned ROW_BW         = $clog2(NUM_ROWS);

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // Largest meaningful shift for a 20-bit lane; larger requests are clamped.
    localparam logic [SHIFT_BW-1:0] SHIFT_MAX = SHIFT_BW'(PARTIAL_SUM_BW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/act_writeback_if.sv
// Result-SRAM read port and unified-buffer write port seen by the write-back stage.
interface act_writeback_if;
    import tpu_pkg::*;

    logic [ADDRESSSIZE-1:0]                res_addr;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_data;
    logic                                  ub_we;
    logic [ADDRESSSIZE-1:0]                ub_addr;
    logic [DATA_BW*MATRIX_SIZE-1:0]        ub_wdata;

    modport master (
        output res_addr,
        input  res_data,
        output ub_we,
        output ub_addr,
        output ub_wdata
    );

    modport slave (
        input  res_addr,
        output res_data,
        input  ub_we,
        input  ub_addr,
        input  ub_wdata
    );

endinterface

// File: rtl/act_quant_lane.sv
// One lane of requantisation: optional ReLU, round-half-up arithmetic shift, saturate to int8.
module act_quant_lane
    import tpu_pkg::*;
(
    input  logic signed [PARTIAL_SUM_BW-1:0] lane_in,
    input  logic                             relu_en,
    input  logic        [SHIFT_BW-1:0]       shift_amt,
    output logic        [DATA_BW-1:0]        lane_out_c
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int unsigned EXT_BW = PARTIAL_SUM_BW + 1;
    localparam logic signed [EXT_BW-1:0] Y_MAX = EXT_BW'(SAT_MAX);
    localparam logic signed [EXT_BW-1:0] Y_MIN = EXT_BW'(SAT_MIN);

    logic signed [EXT_BW-1:0] x_ext;
    logic signed [EXT_BW-1:0] rnd;
    logic signed [EXT_BW-1:0] y;
    logic        [SHIFT_BW-1:0] sh;

    // ReLU, rounding shift and saturation.
    always_comb begin
        x_ext      = '0;
        rnd        = '0;
        y          = '0;
        sh         = (shift_amt > SHIFT_MAX) ? SHIFT_MAX : shift_amt;
        lane_out_c = '0;

        if (!(relu_en && lane_in[PARTIAL_SUM_BW-1])) begin
            x_ext = {lane_in[PARTIAL_SUM_BW-1], lane_in};
        end

        if (sh == '0) begin
            y = x_ext;
        end else begin
            rnd = EXT_BW'(1) << (sh - SHIFT_BW'(1));
            y   = (x_ext + rnd) >>> sh;
        end

        if (y > Y_MAX) begin
            lane_out_c = DATA_BW'(SAT_MAX);
        end else if (y < Y_MIN) begin
            lane_out_c = DATA_BW'(SAT_MIN);
        end else begin
            lane_out_c = y[DATA_BW-1:0];
        end
    end

endmodule

// File: rtl/act_writeback.sv
// Drains NUM_ROWS result rows, requantises every lane and writes the int8 words into the unified buffer.
module act_writeback
    import tpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic [SHIFT_BW-1:0]    shift_amt,
    input  logic [ADDRESSSIZE-1:0] ub_base_addr,
    act_writeback_if.master        bus,
    output logic                   busy,
    output logic                   done
);

    wb_state_e              state;
    logic [ROW_BW-1:0]      row_cnt;
    logic                   rd_valid;    // a read was issued this cycle
    logic                   data_valid;  // SRAM data for that read is present
    logic                   relu_q;
    logic [SHIFT_BW-1:0]    shift_q;
    logic [ADDRESSSIZE-1:0] wr_ptr;
    logic [DATA_BW*MATRIX_SIZE-1:0] quant_word_c;

    // Per-lane requantisation of the word currently on the SRAM read port.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        act_quant_lane u_lane (
            .lane_in    (bus.res_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
            .relu_en    (relu_q),
            .shift_amt  (shift_q),
            .lane_out_c (quant_word_c[i*DATA_BW +: DATA_BW])
        );
    end

    // Control FSM, read issue and write-back pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            row_cnt      <= '0;
            rd_valid     <= 1'b0;
            data_valid   <= 1'b0;
            relu_q       <= 1'b0;
            shift_q      <= '0;
            wr_ptr       <= '0;
            bus.res_addr <= '0;
            bus.ub_we    <= 1'b0;
            bus.ub_addr  <= '0;
            bus.ub_wdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            data_valid <= rd_valid;
            bus.ub_we  <= data_valid;
            done       <= 1'b0;

            if (data_valid) begin
                bus.ub_addr  <= wr_ptr;
                bus.ub_wdata <= quant_word_c;
                wr_ptr       <= wr_ptr + ADDRESSSIZE'(1);
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state        <= READ;
                        busy         <= 1'b1;
                        relu_q       <= relu_en;
                        shift_q      <= shift_amt;
                        wr_ptr       <= ub_base_addr;
                        bus.res_addr <= '0;
                        rd_valid     <= 1'b1;
                        row_cnt      <= ROW_BW'(1);
                    end
                end
                READ: begin
                    bus.res_addr <= ADDRESSSIZE'(row_cnt);
                    rd_valid     <= 1'b1;
                    row_cnt      <= row_cnt + ROW_BW'(1);
                    if (row_cnt == ROW_BW'(NUM_ROWS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rd_valid && !data_valid) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_act_writeback.sv
// Directed bench for act_writeback: lane arithmetic, full drain timing, busy protection, reset abort.
module tb_act_writeback;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic relu_en;
    logic [4:0] shift_amt;
    logic [9:0] ub_base_addr;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    act_writeback_if bus ();

    act_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .relu_en      (relu_en),
        .shift_amt    (shift_amt),
        .ub_base_addr (ub_base_addr),
        .bus          (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Result SRAM model: synchronous read, one-cycle latency.
    logic [159:0] mem [8];
    always @(posedge clk) bus.res_data <= mem[bus.res_addr[2:0]];

    // Per-cycle observations of one drain, cycles 1..12 after the start edge.
    logic        log_we    [13];
    logic [9:0]  log_addr  [13];
    logic [63:0] log_data  [13];
    logic [9:0]  log_raddr [13];
    logic        log_busy  [13];
    logic        log_done  [13];
    logic [63:0] exp_row   [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_all(input logic signed [19:0] v);
        for (int r = 0; r < 8; r++)
            for (int i = 0; i < 8; i++)
                mem[r][i*20 +: 20] = v;
    endtask

    // Start a drain at edge 0 and record cycles 1..12; optionally pulse start again at cycle extra_cyc.
    task automatic run_drain(input logic relu, input logic [4:0] sh, input logic [9:0] base, input int extra_cyc);
        @(negedge clk);
        start = 1'b1; relu_en = relu; shift_amt = sh; ub_base_addr = base;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            log_we[c]    = bus.ub_we;
            log_addr[c]  = bus.ub_addr;
            log_data[c]  = bus.ub_wdata;
            log_raddr[c] = bus.res_addr;
            log_busy[c]  = busy;
            log_done[c]  = done;
            if (c == extra_cyc) begin
                start = 1'b1; relu_en = ~relu; shift_amt = 5'd7; ub_base_addr = 10'h100;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // Full timing check of a drain whose expected words are in exp_row.
    task automatic check_drain(input string tag, input logic [9:0] base);
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("%s_we_c%0d", tag, c), 64'(log_we[c]), 64'(c >= 3 && c <= 10));
            chk($sformatf("%s_done_c%0d", tag, c), 64'(log_done[c]), 64'(c == 11));
            chk($sformatf("%s_busy_c%0d", tag, c), 64'(log_busy[c]), 64'(c <= 11));
            if (c <= 8)
                chk($sformatf("%s_raddr_c%0d", tag, c), 64'(log_raddr[c]), 64'(c - 1));
            if (c >= 3 && c <= 10) begin
                chk($sformatf("%s_addr_c%0d", tag, c), 64'(log_addr[c]), 64'(10'(base + 10'(c - 3))));
                chk($sformatf("%s_data_c%0d", tag, c), log_data[c], exp_row[c-3]);
            end
            if (c >= 11)
                chk($sformatf("%s_hold_c%0d", tag, c), log_data[c], exp_row[7]);
        end
    endtask

    // Lane arithmetic vectors: value in every lane, relu, shift, expected int8.
    logic signed [19:0] vec_val  [10];
    logic               vec_relu [10];
    logic [4:0]         vec_sh   [10];
    logic [7:0]         vec_exp  [10];

    initial begin
        rst = 1'b1; start = 1'b0; relu_en = 1'b0; shift_amt = '0; ub_base_addr = '0;
        for (int r = 0; r < 8; r++) mem[r] = '0;

        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_res_addr", 64'(bus.res_addr), 64'h0);
        chk("rst_ub_we",    64'(bus.ub_we),    64'h0);
        chk("rst_ub_addr",  64'(bus.ub_addr),  64'h0);
        chk("rst_ub_wdata", bus.ub_wdata,      64'h0);
        chk("rst_busy",     64'(busy),         64'h0);
        chk("rst_done",     64'(done),         64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Rounding, saturation, ReLU and shift clamp, checked on all lanes of row 0.
        vec_val[0] = 20'sd1000;    vec_relu[0] = 0; vec_sh[0] = 5'd3;  vec_exp[0] = 8'h7D;
        vec_val[1] = 20'sd3;       vec_relu[1] = 0; vec_sh[1] = 5'd1;  vec_exp[1] = 8'h02;
        vec_val[2] = -20'sd3;      vec_relu[2] = 0; vec_sh[2] = 5'd1;  vec_exp[2] = 8'hFF;
        vec_val[3] = 20'sd5000;    vec_relu[3] = 0; vec_sh[3] = 5'd0;  vec_exp[3] = 8'h7F;
        vec_val[4] = -20'sd5000;   vec_relu[4] = 0; vec_sh[4] = 5'd0;  vec_exp[4] = 8'h80;
        vec_val[5] = -20'sd524288; vec_relu[5] = 0; vec_sh[5] = 5'd19; vec_exp[5] = 8'hFF;
        vec_val[6] = -20'sd37;     vec_relu[6] = 1; vec_sh[6] = 5'd2;  vec_exp[6] = 8'h00;
        vec_val[7] = -20'sd37;     vec_relu[7] = 0; vec_sh[7] = 5'd2;  vec_exp[7] = 8'hF7;
        vec_val[8] = 20'sd262144;  vec_relu[8] = 0; vec_sh[8] = 5'd31; vec_exp[8] = 8'h01;
        vec_val[9] = 20'sd100;     vec_relu[9] = 1; vec_sh[9] = 5'd1;  vec_exp[9] = 8'h32;
        for (int k = 0; k < 10; k++) begin
            fill_all(vec_val[k]);
            run_drain(vec_relu[k], vec_sh[k], 10'h040, 0);
            chk($sformatf("lane_vec%0d", k), log_data[3], {8{vec_exp[k]}});
        end

        // Full drain wrapping the UB address, with an ignored start at cycle 5 and another at the done cycle.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) mem[r][i*20 +: 20] = 20'(r + 1);
            exp_row[r] = {8{8'(r + 1)}};
        end
        run_drain(1'b0, 5'd0, 10'h3FE, 5);
        check_drain("wrap", 10'h3FE);

        run_drain(1'b0, 5'd0, 10'h3FE, 11);
        check_drain("start_at_done", 10'h3FE);
        @(negedge clk);
        chk("start_at_done_idle_busy", 64'(busy), 64'h0);
        chk("start_at_done_idle_we",   64'(bus.ub_we), 64'h0);

        // Reset pulsed in cycle 6 of a drain aborts it.
        @(negedge clk);
        start = 1'b1; relu_en = 1'b0; shift_amt = '0; ub_base_addr = 10'h200;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        chk("abort_we_before_rst", 64'(bus.ub_we), 64'h1);
        rst = 1'b1;
        #1;
        chk("abort_res_addr", 64'(bus.res_addr), 64'h0);
        chk("abort_ub_we",    64'(bus.ub_we),    64'h0);
        chk("abort_ub_addr",  64'(bus.ub_addr),  64'h0);
        chk("abort_ub_wdata", bus.ub_wdata,      64'h0);
        chk("abort_busy",     64'(busy),         64'h0);
        chk("abort_done",     64'(done),         64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 8; c <= 13; c++) begin
            @(negedge clk);
            chk($sformatf("abort_no_we_c%0d", c),   64'(bus.ub_we), 64'h0);
            chk($sformatf("abort_no_done_c%0d", c), 64'(done),      64'h0);
        end

        // Fresh drain after the abort completes normally.
        run_drain(1'b0, 5'd0, 10'h010, 0);
        check_drain("after_abort", 10'h010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
